det_window_counter: RTL
=======================

Name: det_window_counter

Overview:
- Downstream consumer of the serial sequence detector's 1-cycle match pulse (`y`).
- Counts matches over fixed windows of WIN_LEN qualified bit-times and publishes each window's count through a valid/ready holding register.
- Flags windows whose count meets a threshold, and flags results lost to back-pressure.
- Feeds the status/readout logic that sits after the detector.

Parameters:
- WIN_LEN, 32, qualified bit-times per window; must be >= 2.
- CNT_W, 6, width of the match count; the count saturates at 2^CNT_W-1.
- THRESH, 4, alarm asserts when window count >= THRESH; must be <= 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  bit-valid qualifier; high on cycles where a serial bit was presented to the detector.
- det  in  1  detector match output, sampled on the same edge as en.
- clr  in  1  synchronous clear of counters, result, flags.
- cnt_ready  in  1  consumer accepts the result.
- cnt_out  out  CNT_W  match count of the last completed window.
- cnt_valid  out  1  cnt_out holds an unconsumed result.
- alarm  out  1  registered; cnt_out >= THRESH, qualified by cnt_valid.
- overrun  out  1  sticky; an unconsumed result was overwritten.

Behaviour:
- Reset: reset_n low clears all state immediately, independent of clk.
  - cnt_out=0, cnt_valid=0, alarm=0, overrun=0.
  - Bit counter and event counter = 0.
  - Output FSM = EMPTY.
- Counting:
  - Bit counter is clog2(WIN_LEN) wide.
  - It increments on each edge with en=1; en=0 cycles are ignored entirely, including det.
  - Event counter increments on edges with en=1 and det=1.
  - Event counter saturates at 2^CNT_W-1; no wrap.
- Window end:
  - Occurs on the edge with en=1 and bit counter == WIN_LEN-1.
  - det on that final bit is included in the result.
  - On that edge:
    - cnt_out <= final event count.
    - alarm <= (final count >= THRESH).
    - cnt_valid <= 1.
    - Bit counter <= 0.
    - Event counter <= 0.
  - Windows are back-to-back with no dead cycle.
  - Result is visible the cycle after the final bit's edge (latency 1).
- Output FSM, 2 states:
  - EMPTY:
    - cnt_valid=0, alarm=0.
    - Window end -> FULL.
  - FULL:
    - cnt_valid=1.
    - Handshake completes on an edge with cnt_valid=1 and cnt_ready=1.
    - cnt_ready=1 without window end -> EMPTY; cnt_valid and alarm drop after that edge; cnt_out retains its value.
    - cnt_ready=1 with window end -> stays FULL; new result loaded; no overrun.
    - cnt_ready=0 with window end -> stays FULL; new result overwrites; overrun <= 1.
- overrun is sticky; only reset_n or clr clears it.
- clr (synchronous, highest priority after reset):
  - Bit and event counters <= 0; cnt_out <= 0; cnt_valid <= 0; alarm <= 0; overrun <= 0; FSM -> EMPTY.
  - If clr coincides with a window end, no result is loaded.
  - If clr coincides with a handshake, it is harmless.
- cnt_ready while EMPTY: ignored.
- Reset asserted mid-window: the partial window is discarded; counting restarts from bit 0 after release.
- Ports en, det, clr and cnt_ready are synchronous to clk; no internal synchronisers.

Test Plan:
- Reset: hold mid-run state with cnt_valid=1 and overrun=1, pull reset_n low between edges -> all outputs 0 before the next edge. Release, then 8 en cycles with det=0 (WIN_LEN=8) -> cnt_valid=1, cnt_out=0, alarm=0.
- Basic window (WIN_LEN=8, THRESH=4):
  - Stimulus: en=1 continuous, det=1 on bits 1, 3, 5.
  - After 8th bit: cnt_valid=1, cnt_out=3, alarm=0.
  - cnt_ready=1 for one cycle -> cnt_valid=0 next cycle.
- Threshold and last-bit inclusion: det=1 on bits 0, 2, 4, 7 -> cnt_out=4, alarm=1.
- en gaps:
  - Stimulus: en alternates 1/0, det=1 every cycle.
  - Window closes after 8 qualified bits (16 clocks).
  - cnt_out=8 with CNT_W=6; with CNT_W=3, cnt_out=7 (saturated).
- Back-pressure:
  - cnt_ready=0 across two windows with counts 2 then 5 -> cnt_out=5, overrun=1.
  - Repeat with cnt_ready=1 on the second window-end edge -> cnt_out=5, cnt_valid stays 1, overrun=0.
- clr coincident with window end -> cnt_valid=0, cnt_out=0, overrun=0. Next full window reports only its own count.

Source files
------------

// File: rtl/det_window_counter.sv
// Counts detector match pulses over windows of WIN_LEN qualified bits and
// publishes each window count through a valid/ready holding register.
module det_window_counter #(
  parameter int WIN_LEN = 32,
  parameter int CNT_W   = 6,
  parameter int THRESH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             det,
  input  logic             clr,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             alarm,
  output logic             overrun
);

  localparam int BW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [BW-1:0]    LAST = BW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] evt_fin;
  logic             win_end;

  // Count including the current bit, saturating at the top.
  always_comb begin
    evt_fin = evt_q;
    if (det && (evt_q != CMAX)) begin
      evt_fin = evt_q + CNT_W'(1);
    end
  end

  assign win_end = en && (bit_q == LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    evt_d   = evt_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    ovr_d   = ovr_q;

    if (en) begin
      bit_d = bit_q + BW'(1);
      evt_d = evt_fin;
    end

    unique case (state_q)
      EMPTY: begin
        if (win_end) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (cnt_ready && !win_end) begin
          state_d = EMPTY;
          alarm_d = 1'b0;
        end
        if (!cnt_ready && win_end) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (win_end) begin
      bit_d   = '0;
      evt_d   = '0;
      cnt_d   = evt_fin;
      alarm_d = (evt_fin >= THR);
    end

    if (clr) begin
      state_d = EMPTY;
      bit_d   = '0;
      evt_d   = '0;
      cnt_d   = '0;
      alarm_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      bit_q   <= '0;
      evt_q   <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cnt_out   = cnt_q;
  assign cnt_valid = (state_q == FULL);
  assign alarm     = alarm_q;
  assign overrun   = ovr_q;

endmodule
